// File: rtl/adc_acq_capture.sv
// adc_acq_capture: captures ADC samples inside ACQ_EN windows, packs sample pairs into FIFO words and counts echoes.
// Optional build macro ADC_ACQ_ECHO_HEADER_EN: emit a header word {all ones, echo count} at the start of each window.
module adc_acq_capture #(
    parameter int ADC_DATA_WIDTH = 16,
    parameter int ECHO_CNT_WIDTH = 16
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        START,
    input  logic [ECHO_CNT_WIDTH-1:0]   NUM_ECHOES,
    input  logic                        ACQ_EN,
    input  logic [ADC_DATA_WIDTH-1:0]   ADC_DATA,
    output logic [2*ADC_DATA_WIDTH-1:0] FIFO_DATA,
    output logic                        FIFO_WR,
    input  logic                        FIFO_FULL,
    output logic                        BUSY,
    output logic                        DONE,
    output logic                        OVERFLOW,
    output logic [ECHO_CNT_WIDTH-1:0]   ECHO_CNT
);

    localparam int FIFO_WIDTH = 2 * ADC_DATA_WIDTH;
    localparam logic [ECHO_CNT_WIDTH-1:0] ECHO_ONE = {{(ECHO_CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        FINISH  = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [ECHO_CNT_WIDTH-1:0] num_echoes_q, num_echoes_d;
    logic [ECHO_CNT_WIDTH-1:0] echo_cnt_q, echo_cnt_d;
    logic [ECHO_CNT_WIDTH-1:0] echo_cnt_inc_s;
    logic [ADC_DATA_WIDTH-1:0] low_q, low_d;
    logic                      half_q, half_d;
    logic                      acq_en_prev_q, acq_en_prev_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      overflow_q, overflow_d;
    logic                      fifo_wr_q, fifo_wr_d;
    logic [FIFO_WIDTH-1:0]     fifo_data_q, fifo_data_d;
    logic [FIFO_WIDTH-1:0]     word_s;
    logic                      wr_due_s;
    logic                      acq_rise_s;

`ifdef ADC_ACQ_ECHO_HEADER_EN
    function automatic logic [FIFO_WIDTH-1:0] header_word(input logic [ECHO_CNT_WIDTH-1:0] cnt);
        header_word = {{ADC_DATA_WIDTH{1'b1}}, ADC_DATA_WIDTH'(cnt)};
    endfunction
`endif

    assign acq_rise_s     = ACQ_EN & ~acq_en_prev_q;
    assign echo_cnt_inc_s = echo_cnt_q + ECHO_ONE;

    // Next-state and next-output computation for the capture state machine.
    always_comb begin
        state_d       = state_q;
        num_echoes_d  = num_echoes_q;
        echo_cnt_d    = echo_cnt_q;
        low_d         = low_q;
        half_d        = half_q;
        acq_en_prev_d = ACQ_EN;
        busy_d        = busy_q;
        done_d        = 1'b0;
        overflow_d    = overflow_q;
        fifo_wr_d     = 1'b0;
        fifo_data_d   = fifo_data_q;
        word_s        = {FIFO_WIDTH{1'b0}};
        wr_due_s      = 1'b0;

        case (state_q)
            IDLE: begin
                // A START coinciding with the DONE pulse belongs to the finished scan and is dropped.
                if (START && !done_q) begin
                    num_echoes_d = NUM_ECHOES;
                    echo_cnt_d   = {ECHO_CNT_WIDTH{1'b0}};
                    overflow_d   = 1'b0;
                    busy_d       = 1'b1;
                    half_d       = 1'b0;
                    if (NUM_ECHOES == {ECHO_CNT_WIDTH{1'b0}}) begin
                        state_d = FINISH;
                    end else begin
                        state_d = ARMED;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ARMED: begin
                if (acq_rise_s) begin
                    low_d   = ADC_DATA;
                    half_d  = 1'b1;
                    state_d = CAPTURE;
`ifdef ADC_ACQ_ECHO_HEADER_EN
                    word_s   = header_word(echo_cnt_q);
                    wr_due_s = 1'b1;
`endif
                end else begin
                    state_d = ARMED;
                end
            end
            CAPTURE: begin
                if (ACQ_EN) begin
                    if (half_q) begin
                        word_s   = {ADC_DATA, low_q};
                        wr_due_s = 1'b1;
                        half_d   = 1'b0;
                    end else begin
                        low_d  = ADC_DATA;
                        half_d = 1'b1;
                    end
                end else begin
                    if (half_q) begin
                        word_s   = {{ADC_DATA_WIDTH{1'b0}}, low_q};
                        wr_due_s = 1'b1;
                    end else begin
                        wr_due_s = 1'b0;
                    end
                    half_d     = 1'b0;
                    echo_cnt_d = echo_cnt_inc_s;
                    if (echo_cnt_inc_s == num_echoes_q) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ARMED;
                    end
                end
            end
            FINISH: begin
                // BUSY still high here only for a zero-echo scan, whose DONE has not fired yet.
                done_d  = busy_q;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                half_d  = 1'b0;
            end
        endcase

        if (wr_due_s) begin
            if (FIFO_FULL) begin
                overflow_d = 1'b1;
                fifo_wr_d  = 1'b0;
            end else begin
                fifo_wr_d   = 1'b1;
                fifo_data_d = word_s;
            end
        end else begin
            fifo_wr_d = 1'b0;
        end
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= IDLE;
            num_echoes_q  <= {ECHO_CNT_WIDTH{1'b0}};
            echo_cnt_q    <= {ECHO_CNT_WIDTH{1'b0}};
            low_q         <= {ADC_DATA_WIDTH{1'b0}};
            half_q        <= 1'b0;
            acq_en_prev_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            overflow_q    <= 1'b0;
            fifo_wr_q     <= 1'b0;
            fifo_data_q   <= {FIFO_WIDTH{1'b0}};
        end else begin
            state_q       <= state_d;
            num_echoes_q  <= num_echoes_d;
            echo_cnt_q    <= echo_cnt_d;
            low_q         <= low_d;
            half_q        <= half_d;
            acq_en_prev_q <= acq_en_prev_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            overflow_q    <= overflow_d;
            fifo_wr_q     <= fifo_wr_d;
            fifo_data_q   <= fifo_data_d;
        end
    end

    assign FIFO_DATA = fifo_data_q;
    assign FIFO_WR   = fifo_wr_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign OVERFLOW  = overflow_q;
    assign ECHO_CNT  = echo_cnt_q;

endmodule

// File: tb/tb_adc_acq_capture.sv
// Self-checking bench for adc_acq_capture (default build): vector table of single-echo scans plus corner-case sequences.
module tb_adc_acq_capture;

    localparam int DW = 16;
    localparam int EW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [EW-1:0] num_echoes;
    logic          acq_en;
    logic [DW-1:0] adc_data;
    logic [2*DW-1:0] fifo_data;
    logic          fifo_wr;
    logic          fifo_full;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [EW-1:0] echo_cnt;

    int total = 0;
    int bad   = 0;
    logic [2*DW-1:0] exp_q[$];

    typedef struct {
        int len;
        int base;
        int full_word;
        bit exp_ovf;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    adc_acq_capture #(.ADC_DATA_WIDTH(DW), .ECHO_CNT_WIDTH(EW)) dut (
        .CLK(clk), .RESET(rst), .START(start), .NUM_ECHOES(num_echoes),
        .ACQ_EN(acq_en), .ADC_DATA(adc_data), .FIFO_DATA(fifo_data),
        .FIFO_WR(fifo_wr), .FIFO_FULL(fifo_full), .BUSY(busy), .DONE(done),
        .OVERFLOW(overflow), .ECHO_CNT(echo_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Advance one cycle and compare any FIFO write against the scoreboard.
    task automatic step();
        @(posedge clk);
        #1;
        if (fifo_wr !== 1'b0) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got %h required no write", fifo_data);
            end else begin
                chk("fifo_word", fifo_data, exp_q.pop_front());
            end
        end
    endtask

    task automatic push_window(input int len, input int base, input int full_word);
        for (int i = 0; i + 1 < len; i += 2) begin
            if (i / 2 != full_word) exp_q.push_back({DW'(base + i + 1), DW'(base + i)});
        end
        if ((len % 2) == 1 && (len - 1) / 2 != full_word)
            exp_q.push_back({{DW{1'b0}}, DW'(base + len - 1)});
    endtask

    task automatic start_scan(input logic [EW-1:0] n);
        step();
        start      = 1'b1;
        num_echoes = n;
        step();
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("ovf_cleared", {31'd0, overflow}, 32'd0);
        chk("echo_cleared", {16'd0, echo_cnt}, 32'd0);
    endtask

    task automatic run_window(input int len, input int base, input int full_word, input bit last,
                              input logic [EW-1:0] exp_cnt);
        for (int c = 0; c < len + 3; c++) begin
            step();
            acq_en    = (c < len);
            adc_data  = DW'(base + c);
            fifo_full = (full_word >= 0) && (c == 2 * full_word + 1 || c == 2 * full_word + 2);
            if (c == len + 1) begin
                chk("echo_cnt", {16'd0, echo_cnt}, {16'd0, exp_cnt});
                chk("done_at_f1", {31'd0, done}, {31'd0, last});
                chk("busy_at_f1", {31'd0, busy}, {31'd0, !last});
            end
            if (c == len + 2 && last) chk("done_one_cycle", {31'd0, done}, 32'd0);
        end
        acq_en    = 1'b0;
        fifo_full = 1'b0;
    endtask

    task automatic chk_drained(input string name);
        chk(name, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    bit pat[8];

    initial begin
        vecs[0] = '{len: 4, base: 1,     full_word: -1, exp_ovf: 1'b0};
        vecs[1] = '{len: 1, base: 9,     full_word: -1, exp_ovf: 1'b0};
        vecs[2] = '{len: 3, base: 'h20,  full_word: -1, exp_ovf: 1'b0};
        vecs[3] = '{len: 4, base: 'h40,  full_word: 1,  exp_ovf: 1'b1};
        vecs[4] = '{len: 5, base: 'h60,  full_word: 2,  exp_ovf: 1'b1};
        vecs[5] = '{len: 2, base: 'h80,  full_word: -1, exp_ovf: 1'b0};
        vecs[6] = '{len: 6, base: 'hA0,  full_word: 0,  exp_ovf: 1'b1};

        rst = 1'b1; start = 1'b0; num_echoes = '0; acq_en = 1'b0; adc_data = '0; fifo_full = 1'b0;
        step();
        step();
        chk("rst_fifo_wr", {31'd0, fifo_wr}, 32'd0);
        chk("rst_fifo_data", fifo_data, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_echo", {16'd0, echo_cnt}, 32'd0);
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            start_scan(16'd1);
            push_window(vecs[v].len, vecs[v].base, vecs[v].full_word);
            run_window(vecs[v].len, vecs[v].base, vecs[v].full_word, 1'b1, 16'd1);
            chk("vec_overflow", {31'd0, overflow}, {31'd0, vecs[v].exp_ovf});
            chk_drained("vec_words_written");
        end

        // Two echoes: 3-sample then 1-sample window.
        start_scan(16'd2);
        push_window(3, 5, -1);
        push_window(1, 9, -1);
        run_window(3, 5, -1, 1'b0, 16'd1);
        run_window(1, 9, -1, 1'b1, 16'd2);
        chk_drained("two_echo_words");

        // Second window rising exactly one cycle after the first window ends.
        start_scan(16'd2);
        pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_q.push_back({16'h0301, 16'h0300});
        exp_q.push_back({16'h0304, 16'h0303});
        for (int c = 0; c < 8; c++) begin
            step();
            acq_en   = pat[c];
            adc_data = DW'(16'h0300 + c);
            if (c == 6) begin
                chk("b2b_done", {31'd0, done}, 32'd1);
                chk("b2b_echo", {16'd0, echo_cnt}, 32'd2);
            end
        end
        chk_drained("b2b_words");

        // Window already high at START is skipped.
        step();
        start = 1'b1; num_echoes = 16'd1; acq_en = 1'b1; adc_data = 16'h0500;
        for (int c = 1; c < 4; c++) begin
            step();
            start = 1'b0; adc_data = DW'(16'h0500 + c);
        end
        step();
        acq_en = 1'b0;
        step();
        push_window(2, 'h600, -1);
        run_window(2, 'h600, -1, 1'b1, 16'd1);
        chk_drained("prehigh_words");

        // Reset mid-window after three samples.
        start_scan(16'd1);
        exp_q.push_back({16'h0401, 16'h0400});
        for (int c = 0; c < 3; c++) begin
            step();
            acq_en = 1'b1; adc_data = DW'(16'h0400 + c);
        end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; acq_en = 1'b0;
        chk("midrst_fifo_wr", {31'd0, fifo_wr}, 32'd0);
        chk("midrst_fifo_data", fifo_data, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_echo", {16'd0, echo_cnt}, 32'd0);
        step();
        step();
        chk_drained("midrst_no_pad");
        start_scan(16'd1);
        push_window(2, 'h700, -1);
        run_window(2, 'h700, -1, 1'b1, 16'd1);
        chk_drained("after_rst_words");

        // Zero echoes, and a START coinciding with DONE.
        step();
        start = 1'b1; num_echoes = 16'd0;
        step();
        start = 1'b0;
        chk("zero_busy", {31'd0, busy}, 32'd1);
        chk("zero_no_done", {31'd0, done}, 32'd0);
        step();
        chk("zero_done", {31'd0, done}, 32'd1);
        chk("zero_busy_low", {31'd0, busy}, 32'd0);
        start = 1'b1; num_echoes = 16'd1;
        step();
        start = 1'b0;
        chk("start_on_done_ignored", {31'd0, busy}, 32'd0);
        step();
        chk_drained("zero_no_words");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
